rob: RTL
========

ROB -- requirements
Module: rob

Interface
REQ-001 SHALL: ROB_SIZE, default 16, number of entries; tag width is log2(ROB_SIZE) = 4.
REQ-002 SHALL: clk_in  input  1  sole clock, rising edge.
REQ-003 SHALL: rst_in  input  1  asynchronous, active-low reset.
REQ-004 SHALL: rdy_in  input  1  global enable; low freezes all state.
REQ-005 SHALL: issue_valid  input  1  allocate one entry this cycle.
REQ-006 SHALL: issue_rd  input  5  destination register, 0 means no architectural write.
REQ-007 SHALL: issue_tag  output  4  tag of the entry the next issue receives (current tail).
REQ-008 SHALL: rob_full  output  1  high when count == ROB_SIZE.
REQ-009 SHALL: exe_valid / exe_tag / exe_val  input  1/4/32  execution result (ALU or LSB) for a tag.
REQ-010 SHALL: rd_flag / rob_reorder / rd_val  output  1/4/32  registered CDB broadcast to reservation stations.
REQ-011 SHALL: q1_tag, q2_tag  input  4  operand lookup tags; q1_ready, q2_ready  output  1; q1_val, q2_val  output  32.
REQ-012 SHALL: commit_valid / commit_rd / commit_tag / commit_val  output  1/5/4/32  in-order retirement to regfile.
REQ-013 SHALL: flush_in  input  1  discard all entries (mispredict).

Function
REQ-014 SHALL: entries form a circular buffer with head, tail (4-bit, wrap 15->0) and 5-bit count.
REQ-015 SHALL: issue accepted only when issue_valid && !rob_full at the edge; entry[tail] gets busy=1, ready=0, rd=issue_rd; tail++ .
REQ-016 SHALL: issue while rob_full is dropped silently; no state change.
REQ-017 SHALL: exe_valid on a busy, not-ready tag stores exe_val, sets ready at the edge; on a non-busy tag it is ignored.
REQ-018 SHALL: rd_flag=1, rob_reorder=exe_tag, rd_val=exe_val for exactly one cycle after each accepted exe_valid (latency 1).
REQ-019 SHALL: if entry[head] is busy and ready at an edge, it retires: commit_* driven registered for one cycle, busy cleared, head++.
REQ-020 SHALL: minimum latency exe_valid edge N -> commit_valid high in the cycle after edge N+1.
REQ-021 SHALL: at most one issue, one completion, one commit per cycle; count += issue_accepted - committed.
REQ-022 SHALL: rob_full evaluated on registered count; a commit at full does not enable issue in the same cycle.
REQ-023 SHALL: q*_ready/q*_val combinational: ready if entry ready, or exe_valid with exe_tag == q*_tag this cycle (bypass, value = exe_val).
REQ-024 SHALL: flush_in takes priority over issue, completion and commit: head=tail=count=0, all busy cleared, rd_flag=commit_valid=0 next cycle.
REQ-025 SHALL: rdy_in low: no issue, completion, commit or flush; rd_flag and commit_valid drop to 0.
REQ-026 SHALL: commit_rd = 0 entries still retire with commit_valid=1; regfile ignores x0.

Reset
REQ-027 SHALL: on rst_in low, asynchronously: head=tail=count=0, all busy/ready=0, rd_flag=commit_valid=0, rob_reorder=commit_tag=0, rd_val=commit_val=0, commit_rd=0.
REQ-028 SHALL: reset mid-operation discards all in-flight entries; first issue after release gets tag 0.

Structure
REQ-029 SHALL: ROB_SIZE, tag width, RLEN (32), register-address width (5) and bool macros live in the shared defines header.
REQ-030 SHALL: single module, no sub-modules; entry storage as per-field register arrays indexed by tag.

Verification
REQ-031 SHALL: reset, issue rd=5, exe tag 0 val 0x1234 -> rd_flag/rob_reorder=0/rd_val=0x1234 next cycle, commit rd=5 val 0x1234 one cycle later.
REQ-032 SHALL: issue tags 0,1,2; complete 2 then 0 then 1 -> commits strictly 0,1,2 in order.
REQ-033 SHALL: 16 issues -> rob_full=1, 17th issue ignored, tail wraps to 0; after one commit rob_full=0 next cycle and issue_tag=0.
REQ-034 SHALL: q1_tag=3 while exe_valid tag 3 val 0xDEAD -> q1_ready=1, q1_val=0xDEAD same cycle.
REQ-035 SHALL: 4 busy entries, flush_in with simultaneous issue and exe_valid -> count=0, no commit, no rd_flag, next issue_tag=0.
REQ-036 SHALL: rdy_in low for 3 cycles with head ready -> no commit until rdy_in returns high.

Source files
------------

// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_pkg
// Description : Shared sizing constants and boolean literals for the reorder
//               buffer and the blocks that talk to it.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_pkg;

    localparam int   c_ROB_SIZE = 16;                  // number of entries
    localparam int   c_TAG_W    = $clog2(c_ROB_SIZE);  // entry tag width
    localparam int   c_RLEN     = 32;                  // data word width
    localparam int   c_REG_W    = 5;                   // architectural register address width
    localparam logic c_TRUE     = 1'b1;
    localparam logic c_FALSE    = 1'b0;

endpackage
`default_nettype wire

// File: rtl/rob.sv
`default_nettype none
// ============================================================================
// Module      : rob
// Description : Reorder buffer. Circular buffer of in-flight instructions
//               allocated in order, completed out of order by the execution
//               units, and retired in order to the register file. Provides a
//               registered result broadcast and combinational operand lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module rob
    import rob_pkg::*;
#(
    parameter  int ROB_SIZE = c_ROB_SIZE,
    localparam int TAG_W    = $clog2(ROB_SIZE)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    // allocation
    input  logic              issue_valid,
    input  logic [c_REG_W-1:0] issue_rd,
    output logic [TAG_W-1:0]  issue_tag,
    output logic              rob_full,
    // completion from execution units
    input  logic              exe_valid,
    input  logic [TAG_W-1:0]  exe_tag,
    input  logic [c_RLEN-1:0] exe_val,
    // result broadcast to reservation stations
    output logic              rd_flag,
    output logic [TAG_W-1:0]  rob_reorder,
    output logic [c_RLEN-1:0] rd_val,
    // operand lookup
    input  logic [TAG_W-1:0]  q1_tag,
    input  logic [TAG_W-1:0]  q2_tag,
    output logic              q1_ready,
    output logic              q2_ready,
    output logic [c_RLEN-1:0] q1_val,
    output logic [c_RLEN-1:0] q2_val,
    // in-order retirement
    output logic              commit_valid,
    output logic [c_REG_W-1:0] commit_rd,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [c_RLEN-1:0] commit_val,
    // mispredict recovery
    input  logic              flush_in
);

    localparam int CNT_W = TAG_W + 1;

    // pointers and occupancy
    logic [TAG_W-1:0]   r_head_q,  w_head_d;
    logic [TAG_W-1:0]   r_tail_q,  w_tail_d;
    logic [CNT_W-1:0]   r_count_q, w_count_d;

    // per-entry fields, indexed by tag
    logic [ROB_SIZE-1:0] r_busy_q,  w_busy_d;
    logic [ROB_SIZE-1:0] r_ready_q, w_ready_d;
    logic [c_REG_W-1:0]  r_rd_q  [ROB_SIZE];
    logic [c_REG_W-1:0]  w_rd_d  [ROB_SIZE];
    logic [c_RLEN-1:0]   r_val_q [ROB_SIZE];
    logic [c_RLEN-1:0]   w_val_d [ROB_SIZE];

    // registered broadcast and commit outputs
    logic                r_rd_flag_q,      w_rd_flag_d;
    logic [TAG_W-1:0]    r_rob_reorder_q,  w_rob_reorder_d;
    logic [c_RLEN-1:0]   r_rd_val_q,       w_rd_val_d;
    logic                r_commit_valid_q, w_commit_valid_d;
    logic [c_REG_W-1:0]  r_commit_rd_q,    w_commit_rd_d;
    logic [TAG_W-1:0]    r_commit_tag_q,   w_commit_tag_d;
    logic [c_RLEN-1:0]   r_commit_val_q,   w_commit_val_d;

    logic w_issue_acc;
    logic w_exe_acc;
    logic w_commit;

    // Full is taken from the registered count, so a retirement at full only
    // frees a slot for the following cycle.
    assign rob_full    = (r_count_q == CNT_W'(ROB_SIZE));
    assign issue_tag   = r_tail_q;
    assign w_issue_acc = issue_valid && !rob_full;
    assign w_exe_acc   = exe_valid && r_busy_q[exe_tag] && !r_ready_q[exe_tag];
    assign w_commit    = r_busy_q[r_head_q] && r_ready_q[r_head_q];

    // Next-state: frozen when not enabled, flush overrides everything else.
    always_comb begin
        w_head_d         = r_head_q;
        w_tail_d         = r_tail_q;
        w_count_d        = r_count_q;
        w_busy_d         = r_busy_q;
        w_ready_d        = r_ready_q;
        w_rd_d           = r_rd_q;
        w_val_d          = r_val_q;
        w_rd_flag_d      = c_FALSE;
        w_rob_reorder_d  = r_rob_reorder_q;
        w_rd_val_d       = r_rd_val_q;
        w_commit_valid_d = c_FALSE;
        w_commit_rd_d    = r_commit_rd_q;
        w_commit_tag_d   = r_commit_tag_q;
        w_commit_val_d   = r_commit_val_q;

        if (!rdy_in) begin
            // hold everything; strobes already defaulted low
        end else if (flush_in) begin
            w_head_d  = '0;
            w_tail_d  = '0;
            w_count_d = '0;
            w_busy_d  = '0;
            w_ready_d = '0;
        end else begin
            if (w_issue_acc) begin
                w_busy_d[r_tail_q]  = c_TRUE;
                w_ready_d[r_tail_q] = c_FALSE;
                w_rd_d[r_tail_q]    = issue_rd;
                w_tail_d            = r_tail_q + TAG_W'(1);
            end
            if (w_exe_acc) begin
                w_ready_d[exe_tag] = c_TRUE;
                w_val_d[exe_tag]   = exe_val;
                w_rd_flag_d        = c_TRUE;
                w_rob_reorder_d    = exe_tag;
                w_rd_val_d         = exe_val;
            end
            // A retiring head is already ready, so it never collides with a
            // same-cycle completion; and at full no issue can land on it.
            if (w_commit) begin
                w_busy_d[r_head_q]  = c_FALSE;
                w_ready_d[r_head_q] = c_FALSE;
                w_commit_valid_d    = c_TRUE;
                w_commit_rd_d       = r_rd_q[r_head_q];
                w_commit_tag_d      = r_head_q;
                w_commit_val_d      = r_val_q[r_head_q];
                w_head_d            = r_head_q + TAG_W'(1);
            end
            w_count_d = r_count_q + CNT_W'(w_issue_acc) - CNT_W'(w_commit);
        end
    end

    // Control state and output registers, cleared by the asynchronous reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_head_q         <= '0;
            r_tail_q         <= '0;
            r_count_q        <= '0;
            r_busy_q         <= '0;
            r_ready_q        <= '0;
            r_rd_flag_q      <= c_FALSE;
            r_rob_reorder_q  <= '0;
            r_rd_val_q       <= '0;
            r_commit_valid_q <= c_FALSE;
            r_commit_rd_q    <= '0;
            r_commit_tag_q   <= '0;
            r_commit_val_q   <= '0;
        end else begin
            r_head_q         <= w_head_d;
            r_tail_q         <= w_tail_d;
            r_count_q        <= w_count_d;
            r_busy_q         <= w_busy_d;
            r_ready_q        <= w_ready_d;
            r_rd_flag_q      <= w_rd_flag_d;
            r_rob_reorder_q  <= w_rob_reorder_d;
            r_rd_val_q       <= w_rd_val_d;
            r_commit_valid_q <= w_commit_valid_d;
            r_commit_rd_q    <= w_commit_rd_d;
            r_commit_tag_q   <= w_commit_tag_d;
            r_commit_val_q   <= w_commit_val_d;
        end
    end

    // Entry payload storage; contents are only meaningful while busy.
    always_ff @(posedge clk_in) begin
        r_rd_q  <= w_rd_d;
        r_val_q <= w_val_d;
    end

    // Operand lookup with same-cycle bypass from the execution result.
    always_comb begin
        q1_ready = r_ready_q[q1_tag] || (exe_valid && (exe_tag == q1_tag));
        q1_val   = r_ready_q[q1_tag] ? r_val_q[q1_tag] : exe_val;
        q2_ready = r_ready_q[q2_tag] || (exe_valid && (exe_tag == q2_tag));
        q2_val   = r_ready_q[q2_tag] ? r_val_q[q2_tag] : exe_val;
    end

    assign rd_flag      = r_rd_flag_q;
    assign rob_reorder  = r_rob_reorder_q;
    assign rd_val       = r_rd_val_q;
    assign commit_valid = r_commit_valid_q;
    assign commit_rd    = r_commit_rd_q;
    assign commit_tag   = r_commit_tag_q;
    assign commit_val   = r_commit_val_q;

endmodule
`default_nettype wire
